moore_seq_detector: RTL and testbench
=====================================

Name: moore_seq_detector

Overview:
- Parametrised Moore-style serial pattern detector: the next generation of the team's fixed two-state-bit detector.
- Detects a runtime-loadable PAT_W-bit pattern on serial input `a`, with a per-bit don't-care mask and selectable overlapping or non-overlapping mode.
- Counts matches in a saturating counter.
- Sits in the serial-input front end and feeds event counters and status LEDs.

Parameters:
- PAT_W, 2, pattern length in bits (>=2).
- PAT_RST, 2'b01, pattern loaded at reset; MSB is the first bit received.
- MASK_RST, all ones, compare mask loaded at reset (1 = bit compared).
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable; `a` is consumed only on edges where en=1.
- a  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- load  input  1  load pat_in/mask_in and restart detection.
- pat_in  input  PAT_W  new pattern (MSB first received).
- mask_in  input  PAT_W  new compare mask.
- clr_cnt  input  1  synchronous clear of match_cnt.
- y  output  1  match flag (Moore, registered).
- match_cnt  output  CNT_W  saturating match count.
- cnt_sat  output  1  high while match_cnt is all ones.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - pat_q=PAT_RST, mask_q=MASK_RST.
  - hist=0, fill=0, y=0, match_cnt=0, cnt_sat=0.
- State:
  - hist[PAT_W-1:0] is a shift history.
  - fill counts valid bits, 0..PAT_W, saturating at PAT_W.
  - y is the registered match state.
- Edge with load=1:
  - load has priority over en.
  - pat_q<=pat_in, mask_q<=mask_in.
  - hist<=0, fill<=0, y<=0.
  - match_cnt is unaffected unless clr_cnt is also asserted.
- Edge with load=0, en=1:
  - nh={hist[PAT_W-2:0],a}.
  - nf=min(fill+1,PAT_W).
  - hit=(nf==PAT_W) && ((nh ^ pat_q) & mask_q)==0.
  - hist<=nh, y<=hit.
  - fill<=(hit && !overlap) ? 0 : nf.
- Edge with load=0, en=0: hist, fill and y hold; y keeps its previous value.
- Latency: y rises in the cycle after the clock edge that sampled the last pattern bit. It stays high until the next enabled or load edge.
- No false matches on startup: a match requires PAT_W bits received since reset or load, or since the last hit in non-overlap mode. Reset zeros in hist never match.
- Non-overlap: after a hit, the next match needs PAT_W fresh bits.
- Overlap: consecutive hits are possible on consecutive enabled edges, e.g. pattern 11 on input 111.
- mask_q=0 matches every enabled edge once fill reaches PAT_W.
- Changing `overlap` takes effect on the next enabled edge; no state is flushed.
- Counter:
  - On an edge where hit=1, match_cnt increments, saturating at 2^CNT_W-1.
  - clr_cnt sets match_cnt<=0 and wins over a simultaneous hit.
  - cnt_sat = (match_cnt == all ones), registered alongside match_cnt.
- Reset mid-stream: all state clears immediately (asynchronous); a partial pattern is discarded.
- With the default parameters and overlap=1, behaviour is cycle-identical to the existing 0-then-1 detector.

Decomposition:
- Package seq_det_pkg:
  - default PAT_W/CNT_W constants.
  - function match_f(hist, pat, mask) returning the masked compare.
- Sub-module seq_match_counter (CNT_W): saturating counter.
  - Inputs: clk, rst_n, inc, clr.
  - Outputs: cnt, sat.
  - clr has priority over inc.
- Detector core (hist, fill, y) stays in moore_seq_detector.

Test Plan:
- Defaults, overlap=1, en=1, a=1,0,1,0,1 -> y=0,0,1,0,1 on the cycles after each edge; match_cnt=2.
- PAT_W=3, load pat_in=3'b111 mask=3'b111, overlap=1, a=1 x5 -> y high the cycles after edges 3,4,5, match_cnt=3; repeat with overlap=0 -> y high only after edge 3, match_cnt=1.
- en toggling: with pattern 01, a=0 (en=1), then en=0 for 3 cycles with a=1, then a=1 (en=1) -> exactly one hit, on the final edge; y held 0 during the gap, then held 1 after en drops again.
- Mask: PAT_W=3, pattern 3'b101, mask 3'b101, stream 1,1,1 -> hit after edge 3; stream 0,1,1 after reload -> no hit.
- CNT_W=2, overlap=1, mask=0, 6 enabled edges -> match_cnt saturates at 3, cnt_sat=1; clr_cnt on the same edge as a hit -> match_cnt=0.
- rst_n pulsed low mid-pattern (after a=0 with pattern 01), then a=1 -> no hit until a full 0,1 sequence arrives; load during a pending match -> y=0 next cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants, operation encoding and masked-compare helper for the
// parametrised Moore serial pattern detector.
package seq_det_pkg;

  localparam int DEF_PAT_W = 2;
  localparam int DEF_CNT_W = 8;
  localparam int MAX_PAT_W = 32;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2
  } det_op_e;

  // Operands are zero-extended by the caller, so unused upper mask bits never compare.
  function automatic logic match_f(input logic [MAX_PAT_W-1:0] hist,
                                   input logic [MAX_PAT_W-1:0] pat,
                                   input logic [MAX_PAT_W-1:0] mask);
    return ((hist ^ pat) & mask) == '0;
  endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Control/data bundle between the serial front end and the pattern detector.
interface moore_seq_detector_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic             en;
  logic             a;
  logic             overlap;
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic [PAT_W-1:0] mask_in;
  logic             clr_cnt;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, a, overlap, load, pat_in, mask_in, clr_cnt,
    input  y, match_cnt, cnt_sat
  );

  modport slave (
    input  en, a, overlap, load, pat_in, mask_in, clr_cnt,
    output y, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_match_counter.sv
// Saturating match counter; clear wins over increment, saturation flag is
// registered together with the count.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (inc && !(&r_cnt)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= &w_cnt_nxt;
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with loadable pattern/mask, overlap control
// and a saturating match counter.
module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_RST  = PAT_W'(2'b01),
  parameter logic [PAT_W-1:0] MASK_RST = '1,
  parameter int               CNT_W    = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  moore_seq_detector_if.slave  bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-1:0]  r_mask;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_y;

  det_op_e           w_op;
  logic [PAT_W-1:0]  w_nh;
  logic [FILL_W-1:0] w_nf;
  logic              w_hit;
  logic [PAT_W-1:0]  w_hist_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic              w_y_nxt;

  always_comb begin
    w_op = OP_HOLD;
    if (bus.load) begin
      w_op = OP_LOAD;
    end else if (bus.en) begin
      w_op = OP_SHIFT;
    end
  end

  assign w_nh  = {r_hist[PAT_W-2:0], bus.a};
  assign w_nf  = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
  // A full window is required, so reset/load zeros in the history never match.
  assign w_hit = (w_op == OP_SHIFT) && (w_nf == FILL_FULL) &&
                 match_f(MAX_PAT_W'(w_nh), MAX_PAT_W'(r_pat), MAX_PAT_W'(r_mask));

  always_comb begin
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_y_nxt    = r_y;
    unique case (w_op)
      OP_LOAD: begin
        w_hist_nxt = '0;
        w_fill_nxt = '0;
        w_y_nxt    = 1'b0;
      end
      OP_SHIFT: begin
        w_hist_nxt = w_nh;
        w_y_nxt    = w_hit;
        w_fill_nxt = (w_hit && !bus.overlap) ? '0 : w_nf;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat  <= PAT_RST;
      r_mask <= MASK_RST;
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else begin
      if (w_op == OP_LOAD) begin
        r_pat  <= bus.pat_in;
        r_mask <= bus.mask_in;
      end
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_y    <= w_y_nxt;
    end
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hit),
    .clr   (bus.clr_cnt),
    .cnt   (bus.match_cnt),
    .sat   (bus.cnt_sat)
  );

  assign bus.y = r_y;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed self-checking bench: default 2-bit detector, a 3-bit variant and a
// 2-bit-counter variant share one clock and reset.
module tb_moore_seq_detector;
  import seq_det_pkg::*;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   failCount;

  moore_seq_detector_if #(.PAT_W(2), .CNT_W(8)) ifA ();
  moore_seq_detector_if #(.PAT_W(3), .CNT_W(8)) ifB ();
  moore_seq_detector_if #(.PAT_W(2), .CNT_W(2)) ifC ();

  moore_seq_detector #(.PAT_W(2), .CNT_W(8)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  moore_seq_detector #(.PAT_W(3), .CNT_W(8)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
  moore_seq_detector #(.PAT_W(2), .CNT_W(2)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after each rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    ifA.en = 0; ifA.load = 0; ifA.clr_cnt = 0; ifA.a = 0;
    ifB.en = 0; ifB.load = 0; ifB.clr_cnt = 0; ifB.a = 0;
    ifC.en = 0; ifC.load = 0; ifC.clr_cnt = 0; ifC.a = 0;
  endtask

  task automatic loadA(input logic [1:0] pat, input logic [1:0] mask, input logic ovl);
    ifA.load = 1; ifA.pat_in = pat; ifA.mask_in = mask; ifA.overlap = ovl; ifA.clr_cnt = 1;
    tick();
    ifA.load = 0; ifA.clr_cnt = 0;
  endtask

  task automatic loadB(input logic [2:0] pat, input logic [2:0] mask, input logic ovl);
    ifB.load = 1; ifB.pat_in = pat; ifB.mask_in = mask; ifB.overlap = ovl; ifB.clr_cnt = 1;
    tick();
    ifB.load = 0; ifB.clr_cnt = 0;
  endtask

  task automatic test_reset();
    checkCount++;
    if ({ifA.y, ifA.match_cnt, ifA.cnt_sat} !== 10'b0) begin
      failCount++;
      $display("[TB] FAIL reset_A: got y=%b cnt=%0d sat=%b expected 0/0/0", ifA.y, ifA.match_cnt, ifA.cnt_sat);
    end
    checkCount++;
    if ({ifB.y, ifB.match_cnt, ifB.cnt_sat} !== 10'b0) begin
      failCount++;
      $display("[TB] FAIL reset_B: got y=%b cnt=%0d sat=%b expected 0/0/0", ifB.y, ifB.match_cnt, ifB.cnt_sat);
    end
    checkCount++;
    if ({ifC.y, ifC.match_cnt, ifC.cnt_sat} !== 4'b0) begin
      failCount++;
      $display("[TB] FAIL reset_C: got y=%b cnt=%0d sat=%b expected 0/0/0", ifC.y, ifC.match_cnt, ifC.cnt_sat);
    end
  endtask

  // Reset pattern 01, overlap: stream 1,0,1,0,1 gives y 0,0,1,0,1.
  task automatic test_default_pattern();
    logic [4:0] aSeq;
    logic [4:0] yExp;
    aSeq = 5'b10101;
    yExp = 5'b00101;
    ifA.overlap = 1;
    ifA.en = 1;
    for (int i = 0; i < 5; i++) begin
      ifA.a = aSeq[4-i];
      tick();
      checkCount++;
      if (ifA.y !== yExp[4-i]) begin
        failCount++;
        $display("[TB] FAIL default_y[%0d]: got %b expected %b", i, ifA.y, yExp[4-i]);
      end
    end
    ifA.en = 0;
    checkCount++;
    if (ifA.match_cnt !== 8'd2) begin
      failCount++;
      $display("[TB] FAIL default_cnt: got %0d expected 2", ifA.match_cnt);
    end
  endtask

  task automatic test_overlap_modes();
    logic [4:0] yOvl;
    logic [4:0] yNon;
    yOvl = 5'b00111;
    yNon = 5'b00100;
    loadB(3'b111, 3'b111, 1'b1);
    ifB.en = 1; ifB.a = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkCount++;
      if (ifB.y !== yOvl[4-i]) begin
        failCount++;
        $display("[TB] FAIL overlap_y[%0d]: got %b expected %b", i, ifB.y, yOvl[4-i]);
      end
    end
    ifB.en = 0;
    checkCount++;
    if (ifB.match_cnt !== 8'd3) begin
      failCount++;
      $display("[TB] FAIL overlap_cnt: got %0d expected 3", ifB.match_cnt);
    end
    loadB(3'b111, 3'b111, 1'b0);
    ifB.en = 1; ifB.a = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkCount++;
      if (ifB.y !== yNon[4-i]) begin
        failCount++;
        $display("[TB] FAIL nonoverlap_y[%0d]: got %b expected %b", i, ifB.y, yNon[4-i]);
      end
    end
    ifB.en = 0;
    checkCount++;
    if (ifB.match_cnt !== 8'd1) begin
      failCount++;
      $display("[TB] FAIL nonoverlap_cnt: got %0d expected 1", ifB.match_cnt);
    end
  endtask

  task automatic test_enable_gap();
    loadA(2'b01, 2'b11, 1'b1);
    ifA.en = 1; ifA.a = 0;
    tick();
    ifA.en = 0; ifA.a = 1;
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if (ifA.y !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL gap_y[%0d]: got %b expected 0", i, ifA.y);
      end
      if (i < 3) tick();
    end
    ifA.en = 1;
    tick();
    ifA.en = 0; ifA.a = 0;
    checkCount++;
    if (ifA.y !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL gap_hit: got %b expected 1", ifA.y);
    end
    tick();
    tick();
    checkCount++;
    if (ifA.y !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL gap_hold: got %b expected 1", ifA.y);
    end
    checkCount++;
    if (ifA.match_cnt !== 8'd1) begin
      failCount++;
      $display("[TB] FAIL gap_cnt: got %0d expected 1", ifA.match_cnt);
    end
  endtask

  task automatic test_mask();
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] y1;
    s1 = 3'b111; s2 = 3'b011; y1 = 3'b001;
    loadB(3'b101, 3'b101, 1'b1);
    ifB.en = 1;
    for (int i = 0; i < 3; i++) begin
      ifB.a = s1[2-i];
      tick();
      checkCount++;
      if (ifB.y !== y1[2-i]) begin
        failCount++;
        $display("[TB] FAIL mask_hit_y[%0d]: got %b expected %b", i, ifB.y, y1[2-i]);
      end
    end
    ifB.en = 0;
    loadB(3'b101, 3'b101, 1'b1);
    ifB.en = 1;
    for (int i = 0; i < 3; i++) begin
      ifB.a = s2[2-i];
      tick();
      checkCount++;
      if (ifB.y !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL mask_miss_y[%0d]: got %b expected 0", i, ifB.y);
      end
    end
    ifB.en = 0;
    checkCount++;
    if (ifB.match_cnt !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL mask_miss_cnt: got %0d expected 0", ifB.match_cnt);
    end
  endtask

  task automatic test_saturation();
    ifC.load = 1; ifC.pat_in = 2'b10; ifC.mask_in = 2'b00; ifC.overlap = 1; ifC.clr_cnt = 1;
    tick();
    ifC.load = 0; ifC.clr_cnt = 0;
    ifC.en = 1; ifC.a = 0;
    tick();
    checkCount++;
    if (ifC.y !== 1'b0 || ifC.match_cnt !== 2'd0) begin
      failCount++;
      $display("[TB] FAIL sat_first: got y=%b cnt=%0d expected y=0 cnt=0", ifC.y, ifC.match_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      ifC.a = i[0];
      tick();
    end
    checkCount++;
    if (ifC.match_cnt !== 2'd3 || ifC.cnt_sat !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL sat_cnt: got cnt=%0d sat=%b expected cnt=3 sat=1", ifC.match_cnt, ifC.cnt_sat);
    end
    ifC.clr_cnt = 1;
    tick();
    ifC.clr_cnt = 0; ifC.en = 0;
    checkCount++;
    if (ifC.match_cnt !== 2'd0 || ifC.cnt_sat !== 1'b0 || ifC.y !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL sat_clr: got cnt=%0d sat=%b y=%b expected cnt=0 sat=0 y=1",
               ifC.match_cnt, ifC.cnt_sat, ifC.y);
    end
  endtask

  task automatic test_reset_midstream();
    logic [2:0] aSeq;
    logic [2:0] yExp;
    aSeq = 3'b101; yExp = 3'b001;
    loadA(2'b01, 2'b11, 1'b1);
    ifA.en = 1; ifA.a = 0;
    tick();
    ifA.en = 0;
    #2 rst_n = 0;
    #1;
    checkCount++;
    if (ifA.y !== 1'b0 || ifA.match_cnt !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL async_reset: got y=%b cnt=%0d expected 0/0", ifA.y, ifA.match_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    ifA.en = 1;
    for (int i = 0; i < 3; i++) begin
      ifA.a = aSeq[2-i];
      tick();
      checkCount++;
      if (ifA.y !== yExp[2-i]) begin
        failCount++;
        $display("[TB] FAIL post_reset_y[%0d]: got %b expected %b", i, ifA.y, yExp[2-i]);
      end
    end
    ifA.load = 1; ifA.pat_in = 2'b01; ifA.mask_in = 2'b11; ifA.a = 1;
    tick();
    ifA.load = 0; ifA.en = 0;
    checkCount++;
    if (ifA.y !== 1'b0 || ifA.match_cnt !== 8'd1) begin
      failCount++;
      $display("[TB] FAIL load_pending: got y=%b cnt=%0d expected y=0 cnt=1", ifA.y, ifA.match_cnt);
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst_n = 0;
    idleAll();
    ifA.overlap = 1; ifA.pat_in = '0; ifA.mask_in = '0;
    ifB.overlap = 1; ifB.pat_in = '0; ifB.mask_in = '0;
    ifC.overlap = 1; ifC.pat_in = '0; ifC.mask_in = '0;
    #2;
    test_reset();
    #6 rst_n = 1;
    tick();
    test_default_pattern();
    test_overlap_modes();
    test_enable_gap();
    test_mask();
    test_saturation();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
